// File: rtl/dbguart_pkg.sv
// Shared definitions for the debug-UART message printer.
//   LF / SP          : line terminator and field separator characters
//   CMD_*            : message command encodings (cmd field, bits [1:0])
//   hex_char()       : nibble -> lowercase ASCII hex digit
//   ndig()           : hex digits needed for a field of a given bit width
//   line_len()       : characters in one printed line, LF included
package dbguart_pkg;

  localparam logic [7:0] LF = 8'h0a;
  localparam logic [7:0] SP = 8'h20;

  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;
  localparam logic [1:0] CMD_MN = 2'b11;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

  function automatic int ndig(input int w);
    return (w + 3) / 4;
  endfunction

  // ch,cmd and three separators, plus the separator before tags, plus LF = 7
  // fixed characters; each data word costs a separator and 8 digits.
  function automatic int line_len(input int twid, input int bwid, input int awid,
                                  input int dwid, input bit rd);
    return 7 + ndig(twid) + ndig(bwid) + awid / 4 + (rd ? 0 : 9 * (dwid / 32));
  endfunction

endpackage

// File: rtl/dbguart_rr_arbiter.sv
// Round-robin arbiter over NCH requesters.
//   req   : request vector
//   en    : grant allowed this cycle
//   grant : one-hot grant (zero when en=0 or nothing requested)
//   idx   : encoded index of the granted requester
// The pointer holds the highest-priority requester; it moves to the one
// after the winner on every grant and clears to channel 0 on either reset.
module dbguart_rr_arbiter #(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           softreset,
  input  logic [NCH-1:0] req,
  input  logic           en,
  output logic [NCH-1:0] grant,
  output logic [3:0]     idx
);

  logic [3:0] ptr;
  logic       found;
  int         best;
  int         win;

  // Pick the requester with the smallest rotational distance from ptr.
  always_comb begin
    best  = NCH;
    win   = 0;
    grant = '0;
    for (int i = 0; i < NCH; i++) begin
      int d;
      d = i - int'(ptr);
      if (d < 0) d = d + NCH;
      if (req[i] && d < best) begin
        best = d;
        win  = i;
      end
    end
    found = en && (best < NCH);
    for (int i = 0; i < NCH; i++) grant[i] = found && (i == win);
    idx = 4'(win);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ptr <= '0;
    else if (softreset) ptr <= '0;
    else if (found)     ptr <= (win == NCH - 1) ? 4'd0 : 4'(win + 1);
  end

endmodule

// File: rtl/dbguart_msg_printer.sv
// Multi-channel bus-message to hex-text printer for the debug UART.
//   clk, rst_n, softreset : clock, async active-low reset, sync clear
//   msg_in/valid/ready    : NCH message channels, {data,addr,bytes,tags,cmd}
//   tx_data/valid/ready   : byte stream towards the UART TX FIFO
//   busy                  : a line is being emitted
//   line_count            : completed lines, wraps at 16 bits
// One message is captured per line; the character at the current position
// is decoded from the captured fields, so tx_data depends on registers only.
module dbguart_msg_printer
  import dbguart_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DWID = 128,
  parameter int AWID = 32,
  parameter int TWID = 5,
  parameter int BWID = 4,
  parameter int WID  = 2 + DWID + AWID + BWID + TWID
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               softreset,
  input  logic [NCH*WID-1:0] msg_in,
  input  logic [NCH-1:0]     msg_valid,
  output logic [NCH-1:0]     msg_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [15:0]        line_count
);

  localparam int TDIG  = ndig(TWID);
  localparam int BDIG  = ndig(BWID);
  localparam int ADIG  = AWID / 4;
  localparam int NW    = DWID / 32;
  localparam int T0    = 4;               // first tag digit
  localparam int B0    = T0 + TDIG + 1;   // first bytes digit
  localparam int A0    = B0 + BDIG + 1;   // first address digit
  localparam int D0    = A0 + ADIG;       // data SP, or LF on a read line
  localparam int LFULL = line_len(TWID, BWID, AWID, DWID, 1'b0);
  localparam int PW    = $clog2(LFULL);
  localparam int BL    = 2 + TWID;
  localparam int AL    = BL + BWID;
  localparam int DL    = AL + AWID;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]     state;
  logic [PW-1:0]  pos;
  logic [WID-1:0] cap_msg;
  logic [3:0]     cap_ch;
  logic [NCH-1:0] grant;
  logic [3:0]     gidx;
  logic           arb_en;
  logic [WID-1:0] sel_msg;
  logic [7:0]     chr;
  logic           last;

  assign arb_en    = rst_n && (state == S_IDLE) && !softreset;
  assign msg_ready = grant;
  assign tx_valid  = (state == S_EMIT);
  assign busy      = (state == S_EMIT);
  assign tx_data   = (state == S_EMIT) ? chr : 8'h00;

  dbguart_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .softreset(softreset),
    .req      (msg_valid),
    .en       (arb_en),
    .grant    (grant),
    .idx      (gidx)
  );

  always_comb begin
    sel_msg = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) sel_msg = msg_in[i*WID +: WID];
  end

  // Position decoder: each field owns a fixed window of positions; within a
  // window the digit number selects one nibble (MS first) of that field.
  always_comb begin
    int p, q, ni, lf_pos;
    logic [3:0]        nib;
    logic              is_hex;
    logic [4*TDIG-1:0] tag_v;
    logic [4*BDIG-1:0] byt_v;
    p      = int'(pos);
    q      = 0;
    ni     = 0;
    nib    = '0;
    is_hex = 1'b0;
    chr    = SP;
    tag_v  = '0;
    byt_v  = '0;
    tag_v[TWID-1:0] = cap_msg[2 +: TWID];
    byt_v[BWID-1:0] = cap_msg[BL +: BWID];
    lf_pos = (cap_msg[1:0] == CMD_RD) ? D0 : D0 + 9 * NW;
    if (p == 0) begin
      is_hex = 1'b1;
      nib    = cap_ch;
    end else if (p == 2) begin
      is_hex = 1'b1;
      nib    = {2'b00, cap_msg[1:0]};
    end else if (p >= T0 && p < T0 + TDIG) begin
      is_hex = 1'b1;
      ni     = T0 + TDIG - 1 - p;
      for (int i = 0; i < TDIG; i++) if (i == ni) nib = tag_v[4*i +: 4];
    end else if (p >= B0 && p < B0 + BDIG) begin
      is_hex = 1'b1;
      ni     = B0 + BDIG - 1 - p;
      for (int i = 0; i < BDIG; i++) if (i == ni) nib = byt_v[4*i +: 4];
    end else if (p >= A0 && p < A0 + ADIG) begin
      is_hex = 1'b1;
      ni     = A0 + ADIG - 1 - p;
      for (int i = 0; i < ADIG; i++) if (i == ni) nib = cap_msg[AL + 4*i +: 4];
    end else if (p == lf_pos) begin
      chr = LF;
    end else if (p > D0) begin
      // 9-character groups: SP then 8 digits, MS word first
      q = p - D0;
      if (q % 9 != 0) begin
        is_hex = 1'b1;
        ni     = (NW - 1 - q / 9) * 8 + 8 - q % 9;
        for (int i = 0; i < DWID / 4; i++) if (i == ni) nib = cap_msg[DL + 4*i +: 4];
      end
    end
    if (is_hex) chr = hex_char(nib);
    last = (p == lf_pos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pos        <= '0;
      cap_msg    <= '0;
      cap_ch     <= '0;
      line_count <= '0;
    end else if (softreset) begin
      state      <= S_IDLE;
      pos        <= '0;
      cap_msg    <= '0;
      cap_ch     <= '0;
      line_count <= '0;
    end else if (state == S_IDLE) begin
      if (|grant) begin
        cap_msg <= sel_msg;
        cap_ch  <= gidx;
        pos     <= '0;
        state   <= S_EMIT;
      end
    end else if (tx_ready) begin
      if (last) begin
        state      <= S_IDLE;
        line_count <= line_count + 16'd1;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

endmodule
